// File: rtl/timer_irq_source.sv
// CSR-mapped periodic/one-shot timer that drives one level pending request
// toward an n_clic vector line and clears it on the controller's take ack.
module timer_irq_source #(
    parameter logic [11:0] CsrAddr  = 12'h400,
    parameter int          CmpWidth = 16,
    parameter int          PreWidth = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                csr_we,
    input  logic [11:0]         csr_addr,
    input  logic [31:0]         csr_wdata,
    output logic [31:0]         csr_rdata,
    output logic                irq_pend,
    input  logic                irq_ack,
    output logic                irq_overrun,
    output logic [CmpWidth-1:0] count
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [PreWidth-1:0] PreOne = PreWidth'(1);
    localparam logic [CmpWidth-1:0] CmpOne = CmpWidth'(1);

    state_t              state;
    state_t              state_next;
    logic                oneshot;
    logic [3:0]          presc;
    logic [CmpWidth-1:0] cmp;
    logic [CmpWidth-1:0] counter;
    logic [PreWidth-1:0] prescaler;
    logic [PreWidth-1:0] pre_mask;
    logic                wr;
    logic                tick;
    logic                fire;
    logic                unused_wdata;

    assign wr       = csr_we && (csr_addr == CsrAddr);
    assign pre_mask = PreWidth'((32'd1 << presc) - 32'd1);
    assign tick     = (state == RUN) && (prescaler == pre_mask);
    // A CSR write on the same edge as a tick suppresses the fire.
    assign fire     = tick && !wr && (counter == cmp);
    assign count    = counter;

    assign unused_wdata = ^{csr_wdata[15:8], csr_wdata[3:2]};

    always_comb begin
        state_next = state;
        if (wr) begin
            state_next = csr_wdata[0] ? RUN : IDLE;
        end else if (fire && oneshot) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            oneshot     <= 1'b0;
            presc       <= 4'd0;
            cmp         <= '0;
            counter     <= '0;
            prescaler   <= '0;
            irq_pend    <= 1'b0;
            irq_overrun <= 1'b0;
        end else begin
            state <= state_next;
            if (wr) begin
                oneshot     <= csr_wdata[1];
                presc       <= csr_wdata[7:4];
                cmp         <= csr_wdata[16 +: CmpWidth];
                counter     <= '0;
                prescaler   <= '0;
                irq_overrun <= 1'b0;
            end else if (state == RUN) begin
                prescaler <= tick ? '0 : prescaler + PreOne;
                if (tick) begin
                    counter <= (counter == cmp) ? '0 : counter + CmpOne;
                end
            end
            // An ack coinciding with a fire keeps the request up without overrun.
            if (fire) begin
                irq_pend <= 1'b1;
                if (irq_pend && !irq_ack) begin
                    irq_overrun <= 1'b1;
                end
            end else if (irq_ack) begin
                irq_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        if (csr_addr == CsrAddr) begin
            csr_rdata[0]                = (state == RUN);
            csr_rdata[1]                = oneshot;
            csr_rdata[2]                = irq_pend;
            csr_rdata[3]                = irq_overrun;
            csr_rdata[7:4]              = presc;
            csr_rdata[16 +: CmpWidth]   = cmp;
        end
    end

endmodule

// File: tb/tb_timer_irq_source.sv
// Scoreboarded bench for timer_irq_source: an elapsed-time reference model
// pushes the expected state each edge, a negedge monitor pops and compares.
module tb_timer_irq_source;

    localparam logic [11:0] ADDR = 12'h400;

    logic        clk;
    logic        reset;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        irq_pend;
    logic        irq_ack;
    logic        irq_overrun;
    logic [15:0] count;

    timer_irq_source dut (
        .clk        (clk),
        .reset      (reset),
        .csr_we     (csr_we),
        .csr_addr   (csr_addr),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .irq_pend   (irq_pend),
        .irq_ack    (irq_ack),
        .irq_overrun(irq_overrun),
        .count      (count)
    );

    typedef struct {
        bit     pend;
        bit     ov;
        longint cnt;
        bit     en;
        bit     os;
        int     presc;
        int     cmp;
    } exp_t;

    exp_t   q[$];
    int     total = 0;
    int     bad = 0;
    bit     done = 0;

    // Reference model state: elapsed RUN cycles since the last write.
    bit     m_en, m_os, m_pend, m_ov;
    int     m_presc, m_cmp;
    longint m_el;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step();
        exp_t   e;
        bit     fire;
        longint period;
        if (reset) begin
            m_en = 0; m_os = 0; m_pend = 0; m_ov = 0;
            m_presc = 0; m_cmp = 0; m_el = 0;
        end else if (csr_we && csr_addr == ADDR) begin
            m_en    = csr_wdata[0];
            m_os    = csr_wdata[1];
            m_presc = int'(csr_wdata[7:4]);
            m_cmp   = int'(csr_wdata[31:16]);
            m_el    = 0;
            m_ov    = 0;
            if (irq_ack) m_pend = 0;
        end else begin
            fire = 0;
            period = longint'(m_cmp + 1) << m_presc;
            if (m_en) begin
                m_el++;
                if (m_el % period == 0) fire = 1;
            end
            if (fire) begin
                if (m_pend && !irq_ack) m_ov = 1;
                m_pend = 1;
                if (m_os) m_en = 0;
            end else if (irq_ack) begin
                m_pend = 0;
            end
        end
        e.pend  = m_pend;
        e.ov    = m_ov;
        e.cnt   = (m_el >> m_presc) % longint'(m_cmp + 1);
        e.en    = m_en;
        e.os    = m_os;
        e.presc = m_presc;
        e.cmp   = m_cmp;
        q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t        e;
        logic [31:0] r;
        forever begin
            @(negedge clk);
            if (done) break;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty actual=0 required=1 at %0t", $time);
            end else begin
                e = q.pop_front();
                r = '0;
                if (csr_addr == ADDR) begin
                    r = {e.cmp[15:0], 8'h00, e.presc[3:0],
                         e.ov, e.pend, e.os, e.en};
                end
                chk("irq_pend", longint'(irq_pend), longint'(e.pend));
                chk("irq_overrun", longint'(irq_overrun), longint'(e.ov));
                chk("count", longint'(count), e.cnt);
                chk("csr_rdata", longint'(csr_rdata), longint'(r));
            end
        end
    end

    task automatic step(input bit r, input bit we, input logic [11:0] a,
                        input logic [31:0] d, input bit ak);
        reset     = r;
        csr_we    = we;
        csr_addr  = a;
        csr_wdata = d;
        irq_ack   = ak;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cfg(input bit en, input bit os,
                                        input int presc, input int cmp);
        logic [31:0] w;
        w = $urandom;
        w[0] = en;
        w[1] = os;
        w[7:4] = presc[3:0];
        w[31:16] = cmp[15:0];
        return w;
    endfunction

    task automatic run(input int n, input bit ackmode);
        for (int i = 0; i < n; i++) step(0, 0, ADDR, 32'h0, ackmode && m_pend);
    endtask

    initial begin
        int guard;
        step(1, 0, ADDR, 32'h0, 0);
        step(1, 0, ADDR, 32'h0, 0);

        step(0, 1, ADDR, cfg(1, 0, 0, 3), 0);
        run(24, 1);

        step(0, 1, ADDR, cfg(1, 0, 2, 1), 0);
        run(20, 0);

        step(0, 1, ADDR, cfg(1, 1, 0, 2), 1);
        run(24, 0);

        step(0, 1, ADDR, cfg(1, 0, 0, 0), 1);
        run(12, 1);

        step(0, 1, ADDR, cfg(1, 0, 0, 3), 1);
        guard = 0;
        while (!(m_pend && m_el % 4 == 2) && guard < 50) begin
            run(1, 0);
            guard++;
        end
        if (guard >= 50) begin
            total++;
            bad++;
            $display("FAIL reset_setup_timeout actual=%0d required=<50", guard);
        end
        step(1, 0, ADDR, 32'h0, 0);
        step(0, 1, 12'h401, cfg(1, 0, 0, 0), 0);
        run(6, 0);

        for (int i = 0; i < 1500; i++) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 4) begin
                step(0, 1, ADDR, cfg($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                     $urandom_range(0, 3), $urandom_range(0, 5)),
                     $urandom_range(0, 1));
            end else if (sel < 6) begin
                step(0, 1, 12'h000 + 12'($urandom_range(0, 1023)),
                     cfg(1, 0, 0, 0), 0);
            end else if (sel < 7) begin
                step(1, 0, ADDR, 32'h0, 0);
            end else begin
                step(0, 0, ($urandom_range(0, 9) == 0) ? 12'h123 : ADDR,
                     32'h0, $urandom_range(0, 2) == 0);
            end
        end

        step(0, 0, ADDR, 32'h0, 0);
        @(negedge clk);
        #1;
        done = 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
